// File: rtl/sram_fifo_pkg.sv
// ============================================================================
// Package     : sram_fifo_pkg
// Description : Sizing helpers shared by the SRAM-backed streaming FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_fifo_pkg;

    localparam int ADDR_W_DEFAULT = 13;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int pf_depth_of(input int rd_lat);
        return rd_lat + 2;
    endfunction

    // Level covers SRAM contents plus in-flight reads plus prefetch entries.
    function automatic int level_w_of(input int addr_w);
        return addr_w + 2;
    endfunction

    typedef logic [level_w_of(ADDR_W_DEFAULT)-1:0] level_default_t;

endpackage

`default_nettype wire

// File: rtl/sram_if.sv
// ============================================================================
// Interface   : sram_if
// Description : Split read/write port SRAM bus with active-low strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13
);
    logic              rd_l;
    logic              wr_l;
    logic [ADDR_W-1:0] rd_address;
    logic [ADDR_W-1:0] wr_address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport initiator (
        output rd_l, wr_l, rd_address, wr_address, wdata,
        input  rdata
    );

    modport target (
        input  rd_l, wr_l, rd_address, wr_address, wdata,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/sram_fifo_pf.sv
// ============================================================================
// Module      : sram_fifo_pf
// Description : Register-based synchronous prefetch FIFO, any depth >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fifo_pf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 3,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Pointers wrap explicitly since DEPTH need not be a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign occ       = occ_q;
    assign empty     = (occ_q == '0);

endmodule

`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
// ============================================================================
// Module      : sram_fifo_ctrl
// Description : Streams a split-port SRAM as a FIFO with a read prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 13,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W+1:0] level,
    sram_if.initiator         sram
);

    localparam int DEPTH    = depth_of(ADDR_W);
    localparam int PF_DEPTH = pf_depth_of(RD_LAT);
    localparam int PF_OCC_W = $clog2(PF_DEPTH + 1);
    localparam int CNT_W    = ADDR_W + 1;

    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PF_OCC_W:0]   PF_LIMIT  = (PF_OCC_W + 1)'(PF_DEPTH);

    typedef logic [level_w_of(ADDR_W)-1:0] level_t;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [ADDR_W-1:0] wr_address_q, wr_address_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_l_q, wr_l_d;
    logic [CNT_W-1:0]  sram_used_q, sram_used_d;
    logic [CNT_W-1:0]  sram_rdy_q, sram_rdy_d;
    logic              in_ready_q, in_ready_d;
    level_t            level_q, level_d;
    logic [RD_LAT-1:0] vld_q, vld_d;

    logic                accept;
    logic                pop;
    logic                rd_issue;
    logic                capture;
    logic [PF_OCC_W-1:0] inflight;
    logic [PF_OCC_W-1:0] pf_occ;
    logic [PF_OCC_W:0]   credit_used;
    logic                pf_empty;

    assign accept  = in_valid && in_ready_q;
    assign pop     = out_valid && out_ready;
    assign capture = vld_q[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + PF_OCC_W'(vld_q[i]);
        end
    end

    // Credits reserve a prefetch slot for every read before it is issued.
    assign credit_used = {1'b0, inflight} + {1'b0, pf_occ};
    assign rd_issue    = (sram_rdy_q != '0) && (credit_used < PF_LIMIT);

    always_comb begin
        wptr_d       = wptr_q;
        wr_l_d       = 1'b1;
        wr_address_d = wr_address_q;
        wdata_d      = wdata_q;
        if (accept) begin
            wr_l_d       = 1'b0;
            wr_address_d = wptr_q;
            wdata_d      = in_data;
            wptr_d       = wptr_q + 1'b1;
        end

        rptr_d = rd_issue ? rptr_q + 1'b1 : rptr_q;

        // sram_rdy only counts finished writes, so reads never overtake them.
        sram_used_d = sram_used_q + CNT_W'(accept) - CNT_W'(rd_issue);
        sram_rdy_d  = sram_rdy_q + CNT_W'(!wr_l_q) - CNT_W'(rd_issue);
        in_ready_d  = (sram_used_d != DEPTH_CNT);

        level_d = level_q + level_t'(accept) - level_t'(pop);

        vld_d[0] = rd_issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            wr_address_q <= '0;
            wdata_q      <= '0;
            wr_l_q       <= 1'b1;
            sram_used_q  <= '0;
            sram_rdy_q   <= '0;
            in_ready_q   <= 1'b0;
            level_q      <= '0;
            vld_q        <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            wr_address_q <= wr_address_d;
            wdata_q      <= wdata_d;
            wr_l_q       <= wr_l_d;
            sram_used_q  <= sram_used_d;
            sram_rdy_q   <= sram_rdy_d;
            in_ready_q   <= in_ready_d;
            level_q      <= level_d;
            vld_q        <= vld_d;
        end
    end

    sram_fifo_pf #(
        .WIDTH (DATA_W),
        .DEPTH (PF_DEPTH),
        .OCC_W (PF_OCC_W)
    ) u_pf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data (sram.rdata),
        .pop       (pop),
        .head_data (out_data),
        .occ       (pf_occ),
        .empty     (pf_empty)
    );

    assign out_valid = !pf_empty;
    assign in_ready  = in_ready_q;
    assign level     = level_q;

    assign sram.wr_l       = wr_l_q;
    assign sram.wr_address = wr_address_q;
    assign sram.wdata      = wdata_q;
    assign sram.rd_l       = !rd_issue;
    assign sram.rd_address = rptr_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
// ============================================================================
// Module      : tb_sram_fifo_ctrl
// Description : Bench for sram_fifo_ctrl with RD_LAT=1 and RD_LAT=3 instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    logic        in_ready1, out_valid1, in_ready3, out_valid3;
    logic [63:0] out_data1, out_data3;
    logic [4:0]  level1, level3;

    int n_vec = 0;
    int n_err = 0;

    sram_if #(.DATA_W(64), .ADDR_W(3)) s1 ();
    sram_if #(.DATA_W(64), .ADDR_W(3)) s3 ();

    sram_fifo_ctrl #(.DATA_W(64), .ADDR_W(3), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .level(level1), .sram(s1)
    );

    sram_fifo_ctrl #(.DATA_W(64), .ADDR_W(3), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .in_data(in_data), .out_valid(out_valid3), .out_ready(out_ready),
        .out_data(out_data3), .level(level3), .sram(s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro models: rdata is garbage except RD_LAT cycles after a read.
    logic [63:0] mem1 [8];
    logic [63:0] mem3 [8];
    logic [63:0] rp1;
    logic [63:0] rp3 [3];

    always @(posedge clk) begin
        rp1 <= !s1.rd_l ? mem1[s1.rd_address] : {$urandom, $urandom};
        if (!s1.wr_l) mem1[s1.wr_address] <= s1.wdata;
        rp3[0] <= !s3.rd_l ? mem3[s3.rd_address] : {$urandom, $urandom};
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
        if (!s3.wr_l) mem3[s3.wr_address] <= s3.wdata;
    end
    assign s1.rdata = rp1;
    assign s3.rdata = rp3[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: each instance is an ideal FIFO (queue) of accepted words.
    logic [63:0] q1[$];
    logic [63:0] q3[$];
    int          since1, pops1, pops3;
    logic        hold_v1, hold_v3;
    logic [63:0] hold_d1, hold_d3;
    logic [2:0]  exp_wa, exp_ra;
    int          wr_done, rd_iss;

    initial begin
        pops1 = 0;
        pops3 = 0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1.delete(); q3.delete();
            since1 = 0; hold_v1 = 1'b0; hold_v3 = 1'b0;
            exp_wa = '0; exp_ra = '0; wr_done = 0; rd_iss = 0;
        end else begin
            chk("level1", 64'(level1), 64'(q1.size()));
            chk("level3", 64'(level3), 64'(q3.size()));
            chk("lvl_max1", 64'(level1 <= 5'd11), 64'd1);
            chk("lvl_max3", 64'(level3 <= 5'd13), 64'd1);
            if (since1 > 0 && level1 < 5'd8) chk("in_ready1", 64'(in_ready1), 64'd1);
            if (since1 > 0 && level3 < 5'd8) chk("in_ready3", 64'(in_ready3), 64'd1);
            if (q1.size() == 0) chk("ov_empty1", 64'(out_valid1), 64'd0);
            if (q3.size() == 0) chk("ov_empty3", 64'(out_valid3), 64'd0);
            if (hold_v1) begin
                chk("hold_v1", 64'(out_valid1), 64'd1);
                chk("hold_d1", out_data1, hold_d1);
            end
            if (hold_v3) begin
                chk("hold_v3", 64'(out_valid3), 64'd1);
                chk("hold_d3", out_data3, hold_d3);
            end
            hold_v1 = out_valid1 && !out_ready;
            hold_d1 = out_data1;
            hold_v3 = out_valid3 && !out_ready;
            hold_d3 = out_data3;
            if (!s1.rd_l) begin
                chk("rd_addr", 64'(s1.rd_address), 64'(exp_ra));
                chk("rd_hazard", 64'(rd_iss < wr_done), 64'd1);
                exp_ra++; rd_iss++;
            end
            if (!s1.wr_l) begin
                chk("wr_addr", 64'(s1.wr_address), 64'(exp_wa));
                exp_wa++; wr_done++;
            end
            if (in_valid && in_ready1) q1.push_back(in_data);
            if (in_valid && in_ready3) q3.push_back(in_data);
            if (out_valid1 && out_ready) begin
                if (q1.size() == 0) chk("order1_extra", 64'd1, 64'd0);
                else chk("order1", out_data1, q1.pop_front());
                pops1++;
            end
            if (out_valid3 && out_ready) begin
                if (q3.size() == 0) chk("order3_extra", 64'd1, 64'd0);
                else chk("order3", out_data3, q3.pop_front());
                pops3++;
            end
            since1++;
        end
    end

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rd_l"}, 64'(s1.rd_l), 64'd1);
        chk({tag, "_wr_l"}, 64'(s1.wr_l), 64'd1);
        chk({tag, "_rd_a"}, 64'(s1.rd_address), 64'd0);
        chk({tag, "_wr_a"}, 64'(s1.wr_address), 64'd0);
        chk({tag, "_wdata"}, s1.wdata, 64'd0);
        chk({tag, "_ov"}, 64'(out_valid1), 64'd0);
        chk({tag, "_od"}, out_data1, 64'd0);
        chk({tag, "_level"}, 64'(level1), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready1), 64'd0);
        chk({tag, "_level3"}, 64'(level3), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready1", 64'(in_ready1), 64'd1);
        chk("rst_in_ready3", 64'(in_ready3), 64'd1);
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0; out_ready = 1'b1; n = 0;
        while ((level1 != 0 || level3 != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(n < 200), 64'd1);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_q3", 64'(q3.size()), 64'd0);
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       wr_l;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       rd_l;
        logic [2:0] ra;
        logic       ov;
        logic [7:0] od;
        logic [4:0] lvl;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int n, p1, p3;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Cycle-exact single-word latency, then two words with a stall.
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 5'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 8'hA5, 1'b1, 3'd0, 1'b0, 8'h00, 5'd1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 1'b0, 8'h00, 5'd1};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 5'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 8'hA5, 5'd1};
        tbl[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 5'd0};
        tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd1, 8'h11, 1'b1, 3'd0, 1'b0, 8'h00, 5'd1};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd2, 8'h22, 1'b0, 3'd1, 1'b0, 8'h00, 5'd2};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 8'h00, 5'd2};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h11, 5'd2};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h11, 5'd2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 8'h22, 5'd1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 5'd0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("t%0d_wr_l", i), 64'(s1.wr_l), 64'(tbl[i].wr_l));
            if (!tbl[i].wr_l) begin
                chk($sformatf("t%0d_wr_a", i), 64'(s1.wr_address), 64'(tbl[i].wa));
                chk($sformatf("t%0d_wdata", i), s1.wdata, 64'(tbl[i].wd));
            end
            chk($sformatf("t%0d_rd_l", i), 64'(s1.rd_l), 64'(tbl[i].rd_l));
            if (!tbl[i].rd_l) chk($sformatf("t%0d_rd_a", i), 64'(s1.rd_address), 64'(tbl[i].ra));
            chk($sformatf("t%0d_ov", i), 64'(out_valid1), 64'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("t%0d_od", i), out_data1, 64'(tbl[i].od));
            chk($sformatf("t%0d_level", i), 64'(level1), 64'(tbl[i].lvl));
            in_valid  = tbl[i].iv;
            in_data   = 64'(tbl[i].id);
            out_ready = tbl[i].ordy;
            @(negedge clk);
        end
        drain();

        // Random stream: many pointer wraps, random backpressure on both sides.
        for (int c = 0; c < 200; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
        end
        drain();

        // Continuous push with out_ready toggling every cycle.
        for (int c = 0; c < 60; c++) begin
            in_valid  = 1'b1;
            in_data   = {$urandom, $urandom};
            out_ready = c[0];
            @(negedge clk);
        end
        drain();

        // Sustained throughput: one output per cycle once the pipe is full.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = {$urandom, $urandom};
            @(negedge clk);
        end
        p1 = pops1; p3 = pops3;
        for (int c = 0; c < 40; c++) begin
            in_data = {$urandom, $urandom};
            @(negedge clk);
        end
        chk("thru_lat1", 64'(pops1 - p1), 64'd40);
        chk("thru_lat3", 64'(pops3 - p3), 64'd40);
        drain();

        // Reset mid-burst, asserted in the first rd_l-low cycle.
        do_reset();
        out_ready = 1'b0; n = 0;
        while (s1.rd_l && n < 20) begin
            in_valid = (n < 5);
            in_data  = 64'(32'hB000 + n);
            @(negedge clk);
            n++;
        end
        chk("midrst_rd_timeout", 64'(n < 20), 64'd1);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("midrst_ov", 64'(out_valid1), 64'd0);
            chk("midrst_level", 64'(level1), 64'd0);
        end
        in_valid = 1'b1; in_data = 64'h77;
        @(negedge clk);
        in_valid = 1'b0; n = 0;
        while (!out_valid1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_fresh_timeout", 64'(n < 10), 64'd1);
        chk("midrst_fresh_data", out_data1, 64'h77);
        drain();

        // Fill with the output stalled: SRAM full plus a full prefetch.
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1;
            in_data  = 64'(32'hF000 + c);
            @(negedge clk);
        end
        chk("fill_level1", 64'(level1), 64'd11);
        chk("fill_in_ready1", 64'(in_ready1), 64'd0);
        chk("fill_q1", 64'(q1.size()), 64'd11);
        chk("fill_level3", 64'(level3), 64'd13);
        chk("fill_in_ready3", 64'(in_ready3), 64'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Initiator-side controller that turns a single-port-per-direction SRAM (sram_if, separate read and write address buses) into a streaming FIFO.
- Upstream: valid/ready write stream. Downstream: valid/ready read stream fed from a small prefetch buffer that hides the SRAM read latency.
- Sits directly upstream of the SRAM macro wrapper and drives its target modport.

Parameters:
- DATA_W, 64, word width; must match the connected sram_if.
- ADDR_W, 13, SRAM address width; FIFO depth DEPTH = 2**ADDR_W.
- RD_LAT, 1, cycles from rd_l low to valid rdata (1..3).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  write-stream valid
- in_ready  out  1  write-stream ready
- in_data  in  DATA_W  write-stream data
- out_valid  out  1  read-stream valid
- out_ready  in  1  read-stream ready
- out_data  out  DATA_W  read-stream data
- level  out  ADDR_W+2  words held (SRAM + in-flight reads + prefetch)
- sram  sram_if.initiator  -  rd_l/wr_l active-low strobes, rd_address, wr_address, wdata out; rdata in

Behaviour:
- Reset (rst_n low, async): rd_l=1, wr_l=1, rd_address=0, wr_address=0, wdata=0, out_valid=0, out_data=0, level=0, in_ready=0. All pointers and counters cleared; in-flight reads discarded, rdata ignored. in_ready=1 from the first cycle after deassertion.
- Write path: accept on in_valid&&in_ready in cycle N. In cycle N+1: wr_l=0, wr_address=wptr, wdata=in_data. wptr increments (ADDR_W bits, wraps mod DEPTH). wr_l=1 otherwise.
- Counters:
  - sram_used: +1 on accept, -1 on read issue.
  - sram_rdy: +1 at the end of each wr_l-low cycle, -1 on read issue.
  - in_ready = (sram_used != DEPTH), from the registered count. A read issued in the same cycle does not release a slot until the next cycle.
- Read issue: in cycle M, issue when sram_rdy>0 && (inflight+pf_occ) < RD_LAT+2. rd_l=0, rd_address=rptr, rptr increments (wraps). inflight tracked by an RD_LAT-deep valid shift register.
- No read-during-write hazard: sram_rdy counts only completed writes, so rd_address never equals a same-cycle wr_address with unwritten data.
- Capture: rdata is valid in cycle M+RD_LAT and is written into the prefetch FIFO (depth RD_LAT+2) at the end of that cycle. The credit check guarantees the prefetch FIFO never overflows.
- Output: out_valid = prefetch not empty; out_data = head entry, stable while out_valid&&!out_ready. Pop on out_valid&&out_ready.
- Latency (RD_LAT=1, empty FIFO, out_ready=1): accept cycle 0, wr_l low cycle 1, rd_l low cycle 2, rdata cycle 3, out_valid cycle 4.
- level: registered = sram_used + inflight + pf_occ. Simultaneous push and pop leave it unchanged; max DEPTH+RD_LAT+2.
- Full: in_ready=0 while sram_used==DEPTH; in_data is ignored.
- Empty: out_valid=0; out_ready is don't-care.
- Ordering: strict FIFO order across pointer wrap.

Decomposition:
- Package sram_fifo_pkg holds:
  - the function clog2-free depth constant DEPTH(ADDR_W);
  - PF_DEPTH(RD_LAT) = RD_LAT+2;
  - a typedef for the level width.
- One sub-module, sram_fifo_pf: a parameterised register-based sync FIFO (width DATA_W, depth PF_DEPTH) with push, pop, occupancy and empty.

Test Plan:
- Reset mid-burst: push 5 words, assert rst_n low during the rd_l-low cycle → all outputs return to reset values immediately; after release, level=0 and out_valid=0, and no stale data appears.
- Single word, RD_LAT=1: push 0xA5 at cycle 0 → wr_l low cycle 1 at addr 0; rd_l low cycle 2 at addr 0; out_valid=1 with out_data=0xA5 at cycle 4.
- Fill, ADDR_W=3, out_ready=0: push 16 words → in_ready drops once sram_used==8 after 3 prefetch reads. level=11 (8 in SRAM + 3 in prefetch) with RD_LAT=1, where 8+3 = DEPTH+RD_LAT+2 = 8+1+2; the 9th SRAM word is refused.
- Wrap, ADDR_W=3: stream 20 words with random in_valid/out_ready → output sequence equals input sequence; addresses wrap 7→0.
- Backpressure: out_ready toggles every cycle with continuous push → out_data holds while stalled, no beat lost or duplicated, prefetch never exceeds RD_LAT+2.
- RD_LAT=3 throughput: continuous push/pop with out_ready=1 → after fill, one output per cycle sustained.
